debounce_bank: RTL and testbench

DEBOUNCE_BANK -- requirements
Module: debounce_bank

---
 rtl/debounce_bank.sv | 130 +++++++++++++
 tb/tb_debounce_bank.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/debounce_bank.sv
// -----------------------------------------------------------------------------
// debounce_bank
//
// Bank of independent input debouncers sharing one clock and one sample
// strobe. Each channel synchronises its raw asynchronous input. On each
// tick it then counts consecutive samples that disagree with the current
// filtered level. The level changes only after STABLE_CNT such ticks in a
// row. With MODE 0, a falling input bypasses the filter and drops the level
// on the first tick that sees it.
//
// Parameters
//   CHANNELS    : number of channels (1..32)
//   STABLE_CNT  : consecutive disagreeing ticks needed to change a level (1..255)
//   SYNC_STAGES : synchroniser depth per channel (1..3)
//   MODE        : 0 = filtered assert / immediate deassert, 1 = symmetric filter
//
// Ports
//   clk        in   rising-edge clock for all state
//   reset_n    in   asynchronous active-low reset
//   tick       in   sample strobe; the filter advances only when high
//   in_raw     in   [CHANNELS] raw asynchronous inputs
//   out_level  out  [CHANNELS] filtered level, registered
//   rise_pulse out  [CHANNELS] one-cycle strobe on out_level 0->1
//   fall_pulse out  [CHANNELS] one-cycle strobe on out_level 1->0
//   any_active out  OR of all filtered levels, aligned with out_level
// -----------------------------------------------------------------------------
module debounce_bank #(
  parameter int unsigned CHANNELS    = 4,
  parameter int unsigned STABLE_CNT  = 4,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned MODE        = 1
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                tick,
  input  logic [CHANNELS-1:0] in_raw,
  output logic [CHANNELS-1:0] out_level,
  output logic [CHANNELS-1:0] rise_pulse,
  output logic [CHANNELS-1:0] fall_pulse,
  output logic                any_active
);

  // Counter is wide enough to hold STABLE_CNT itself. It saturates there.
  localparam int unsigned CW = $clog2(STABLE_CNT + 1);

  localparam logic [CW-1:0] CNT_ZERO  = CW'(0);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);
  localparam logic [CW-1:0] CNT_LAST  = CW'(STABLE_CNT);
  localparam bit            FAST_FALL = (MODE == 32'd0);

  // Synchroniser chain. Stage 0 sees in_raw. The last stage is the sample.
  logic [SYNC_STAGES-1:0][CHANNELS-1:0] sync_r;
  logic [CHANNELS-1:0]                  sample_s;

  // Per-channel disagreement counters and their next state.
  logic [CHANNELS-1:0][CW-1:0] cnt_r;
  logic [CHANNELS-1:0][CW-1:0] cnt_nxt_s;
  logic [CHANNELS-1:0]         level_nxt_s;

  // Saturating increment. The counter holds at STABLE_CNT and never wraps.
  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    logic [CW-1:0] r;
    if (v == CNT_LAST) begin
      r = v;
    end else begin
      r = v + CNT_ONE;
    end
    return r;
  endfunction

  assign sample_s = sync_r[SYNC_STAGES-1];

  // Filter next-state: counters and levels advance only on tick cycles.
  always_comb begin
    cnt_nxt_s   = cnt_r;
    level_nxt_s = out_level;
    for (int i = 0; i < CHANNELS; i++) begin
      if (tick) begin
        if (sample_s[i] == out_level[i]) begin
          // An agreeing sample breaks any disagreement run.
          cnt_nxt_s[i] = CNT_ZERO;
        end else if (FAST_FALL && !sample_s[i]) begin
          // A falling input drops the level at once, whatever the count.
          level_nxt_s[i] = 1'b0;
          cnt_nxt_s[i]   = CNT_ZERO;
        end else if (sat_inc(cnt_r[i]) == CNT_LAST) begin
          // This is the STABLE_CNT-th disagreeing tick in a row.
          level_nxt_s[i] = sample_s[i];
          cnt_nxt_s[i]   = CNT_ZERO;
        end else begin
          cnt_nxt_s[i] = sat_inc(cnt_r[i]);
        end
      end else begin
        cnt_nxt_s[i]   = cnt_r[i];
        level_nxt_s[i] = out_level[i];
      end
    end
  end

  // Synchroniser chain. It shifts every cycle, whether tick is high or not.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_r <= '0;
    end else begin
      sync_r[0] <= in_raw;
      for (int k = 1; k < SYNC_STAGES; k++) begin
        sync_r[k] <= sync_r[k-1];
      end
    end
  end

  // Filter state and registered outputs. Edge pulses come from the level
  // changing. On a non-tick cycle the level holds, so both pulses stay low.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_r      <= '0;
      out_level  <= '0;
      rise_pulse <= '0;
      fall_pulse <= '0;
      any_active <= 1'b0;
    end else begin
      cnt_r      <= cnt_nxt_s;
      out_level  <= level_nxt_s;
      rise_pulse <= level_nxt_s & ~out_level;
      fall_pulse <= ~level_nxt_s & out_level;
      any_active <= |level_nxt_s;
    end
  end

endmodule

// File: tb/tb_debounce_bank.sv
// -----------------------------------------------------------------------------
// tb_debounce_bank
//
// Scoreboard bench for debounce_bank. It builds two instances:
//   dut_a : CHANNELS=4, STABLE_CNT=4, SYNC_STAGES=2, MODE=1
//   dut_b : CHANNELS=4, STABLE_CNT=4, SYNC_STAGES=2, MODE=0
//
// Stimulus is applied on falling edges. Each expectation is tagged with the
// cycle count at which it must hold and is pushed into a queue. A monitor
// wakes shortly after every falling edge and pops and compares any entries
// that are due.
// -----------------------------------------------------------------------------
module tb_debounce_bank;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       tick_a, tick_b;
  logic [3:0] in_a, in_b;
  logic [3:0] lvl_a, rise_a, fall_a;
  logic [3:0] lvl_b, rise_b, fall_b;
  logic       any_a, any_b;

  int cyc    = 0;
  int checks = 0;
  int errors = 0;

  typedef struct {
    bit         which;
    int         cyc;
    logic [3:0] lvl;
    logic [3:0] rise;
    logic [3:0] fall;
    logic       any;
    string      name;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  debounce_bank #(.CHANNELS(4), .STABLE_CNT(4), .SYNC_STAGES(2), .MODE(1)) dut_a (
    .clk(clk), .reset_n(reset_n), .tick(tick_a), .in_raw(in_a),
    .out_level(lvl_a), .rise_pulse(rise_a), .fall_pulse(fall_a), .any_active(any_a)
  );

  debounce_bank #(.CHANNELS(4), .STABLE_CNT(4), .SYNC_STAGES(2), .MODE(0)) dut_b (
    .clk(clk), .reset_n(reset_n), .tick(tick_b), .in_raw(in_b),
    .out_level(lvl_b), .rise_pulse(rise_b), .fall_pulse(fall_b), .any_active(any_b)
  );

  // Queue an expectation for the outputs seen after the n-th rising edge from now.
  task automatic push(input bit which, input int n, input logic [3:0] l,
                      input logic [3:0] r, input logic [3:0] f, input logic a,
                      input string nm);
    exp_t e;
    e.which = which; e.cyc = cyc + n; e.lvl = l; e.rise = r; e.fall = f;
    e.any = a; e.name = nm;
    sb.push_back(e);
  endtask

  // Monitor: compare every expectation that falls due on this cycle.
  initial begin
    forever begin
      @(negedge clk);
      #1;
      while (sb.size() > 0 && sb[0].cyc <= cyc) begin
        exp_t e;
        logic [3:0] l, r, f;
        logic a;
        e = sb.pop_front();
        l = e.which ? lvl_b  : lvl_a;
        r = e.which ? rise_b : rise_a;
        f = e.which ? fall_b : fall_a;
        a = e.which ? any_b  : any_a;
        checks++;
        if (e.cyc != cyc) begin
          errors++;
          $display("FAIL %s: expectation for cycle %0d was overdue at cycle %0d",
                   e.name, e.cyc, cyc);
        end else if (l !== e.lvl || r !== e.rise || f !== e.fall || a !== e.any) begin
          errors++;
          $display("FAIL %s (dut_%s, cycle %0d): got lvl=%b rise=%b fall=%b any=%b, want lvl=%b rise=%b fall=%b any=%b",
                   e.name, e.which ? "b" : "a", cyc, l, r, f, a, e.lvl, e.rise, e.fall, e.any);
        end
      end
    end
  end

  // Directed stimulus.
  initial begin
    reset_n = 1'b0; tick_a = 1'b1; tick_b = 1'b1; in_a = 4'h0; in_b = 4'h0;

    // Reset state, then no activity on the first edge after release.
    @(negedge clk);
    push(1'b0, 0, 4'h0, 4'h0, 4'h0, 1'b0, "reset_state_a");
    push(1'b1, 0, 4'h0, 4'h0, 4'h0, 1'b0, "reset_state_b");
    @(negedge clk);
    reset_n = 1'b1;
    push(1'b0, 1, 4'h0, 4'h0, 4'h0, 1'b0, "first_edge_after_release");
    repeat (3) @(negedge clk);

    // Channel 0 rises: level and pulse appear at edge 6, pulse gone at edge 7.
    in_a = 4'h1;
    push(1'b0, 5, 4'h0, 4'h0, 4'h0, 1'b0, "ch0_rise_edge5");
    push(1'b0, 6, 4'h1, 4'h1, 4'h0, 1'b1, "ch0_rise_edge6");
    push(1'b0, 7, 4'h1, 4'h0, 4'h0, 1'b1, "ch0_rise_edge7");
    repeat (9) @(negedge clk);

    // Channel 1 high for only 3 cycles: too short to pass the filter.
    in_a = 4'h3;
    push(1'b0, 5, 4'h1, 4'h0, 4'h0, 1'b1, "ch1_glitch_edge5");
    push(1'b0, 6, 4'h1, 4'h0, 4'h0, 1'b1, "ch1_glitch_edge6");
    push(1'b0, 8, 4'h1, 4'h0, 4'h0, 1'b1, "ch1_glitch_edge8");
    repeat (3) @(negedge clk);
    in_a = 4'h1;
    repeat (8) @(negedge clk);

    // Symmetric fall on channel 0.
    in_a = 4'h0;
    push(1'b0, 5, 4'h1, 4'h0, 4'h0, 1'b1, "ch0_fall_edge5");
    push(1'b0, 6, 4'h0, 4'h0, 4'h1, 1'b0, "ch0_fall_edge6");
    push(1'b0, 7, 4'h0, 4'h0, 4'h0, 1'b0, "ch0_fall_edge7");
    repeat (9) @(negedge clk);

    // Channels 1 and 3 rise together. Channels 0 and 2 stay low.
    in_a = 4'hA;
    push(1'b0, 5, 4'h0, 4'h0, 4'h0, 1'b0, "multi_rise_edge5");
    push(1'b0, 6, 4'hA, 4'hA, 4'h0, 1'b1, "multi_rise_edge6");
    push(1'b0, 7, 4'hA, 4'h0, 4'h0, 1'b1, "multi_rise_edge7");
    repeat (9) @(negedge clk);
    in_a = 4'h0;
    push(1'b0, 6, 4'h0, 4'h0, 4'hA, 1'b0, "multi_fall_edge6");
    repeat (9) @(negedge clk);

    // Tick every 4th cycle. Ticks land on edges 4,8,12,16,20, so the level
    // rises at edge 16 and holds over the non-tick edges after it.
    in_a   = 4'h8;
    tick_a = 1'b0;
    push(1'b0, 13, 4'h0, 4'h0, 4'h0, 1'b0, "slow_tick_edge13");
    push(1'b0, 15, 4'h0, 4'h0, 4'h0, 1'b0, "slow_tick_edge15");
    push(1'b0, 16, 4'h8, 4'h8, 4'h0, 1'b1, "slow_tick_edge16");
    push(1'b0, 17, 4'h8, 4'h0, 4'h0, 1'b1, "slow_tick_hold17");
    push(1'b0, 19, 4'h8, 4'h0, 4'h0, 1'b1, "slow_tick_hold19");
    for (int k = 1; k < 20; k++) begin
      @(negedge clk);
      tick_a = ((k % 4) == 3);
    end
    @(negedge clk);
    tick_a = 1'b1;
    in_a   = 4'h0;
    repeat (10) @(negedge clk);

    // All inputs high, reset mid-count after edge 4, then the filter restarts.
    in_a = 4'hF;
    repeat (4) @(negedge clk);
    reset_n = 1'b0;
    push(1'b0, 0, 4'h0, 4'h0, 4'h0, 1'b0, "reset_async_clear");
    @(negedge clk);
    push(1'b0, 0, 4'h0, 4'h0, 4'h0, 1'b0, "reset_held");
    @(negedge clk);
    reset_n = 1'b1;
    push(1'b0, 1, 4'h0, 4'h0, 4'h0, 1'b0, "release_no_pulse");
    push(1'b0, 5, 4'h0, 4'h0, 4'h0, 1'b0, "release_edge5");
    push(1'b0, 6, 4'hF, 4'hF, 4'h0, 1'b1, "release_edge6");
    push(1'b0, 7, 4'hF, 4'h0, 4'h0, 1'b1, "release_edge7");
    repeat (9) @(negedge clk);
    in_a = 4'h0;
    repeat (9) @(negedge clk);

    // MODE 0: the rise is filtered, but the fall is immediate at edge 3.
    in_b = 4'h4;
    push(1'b1, 5, 4'h0, 4'h0, 4'h0, 1'b0, "m0_rise_edge5");
    push(1'b1, 6, 4'h4, 4'h4, 4'h0, 1'b1, "m0_rise_edge6");
    push(1'b1, 7, 4'h4, 4'h0, 4'h0, 1'b1, "m0_rise_edge7");
    repeat (9) @(negedge clk);
    in_b = 4'h0;
    push(1'b1, 2, 4'h4, 4'h0, 4'h0, 1'b1, "m0_fall_edge2");
    push(1'b1, 3, 4'h0, 4'h0, 4'h4, 1'b0, "m0_fall_edge3");
    push(1'b1, 4, 4'h0, 4'h0, 4'h0, 1'b0, "m0_fall_edge4");
    repeat (8) @(negedge clk);

    // Anything still queued means the monitor never reached it.
    #2;
    while (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      checks++;
      errors++;
      $display("FAIL %s: expectation for cycle %0d never checked (now %0d)", e.name, e.cyc, cyc);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
